// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the fetch unit's memory-port and downstream-handshake signals.
//   master : fetch unit side (drives instr_addr, ir_out, ir_valid, pc_out)
//   slave  : memory / decode / redirect side
//   Signals:
//     instr_addr  [ADDR_W]   address to the instruction memory port
//     instr_in    [INSTR_W]  word returned by the instruction memory
//     ir_out      [INSTR_W]  registered instruction to decode
//     ir_valid               ir_out holds a valid instruction
//     ir_ready               downstream accepts ir_out this cycle
//     pc_load                redirect request (1-cycle pulse)
//     pc_load_val [ADDR_W]   redirect target
//     pc_out      [ADDR_W]   address of the instruction in ir_out
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  instr_addr;
  logic [INSTR_W-1:0] instr_in;
  logic [INSTR_W-1:0] ir_out;
  logic               ir_valid;
  logic               ir_ready;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_val;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output instr_addr, ir_out, ir_valid, pc_out,
    input  instr_in, ir_ready, pc_load, pc_load_val
  );

  modport slave (
    input  instr_addr, ir_out, ir_valid, pc_out,
    output instr_in, ir_ready, pc_load, pc_load_val
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Per-core fetch stage. Owns the PC, drives one instruction-memory address
//   port, waits out the memory read latency, captures the returned word into
//   an instruction register and hands it downstream with valid/ready.
//   Supports PC redirect and stops on the HALT opcode.
//
//   Ports:
//     clock        single clock, posedge
//     reset        synchronous, active-high
//     start        begin fetching (IDLE) / restart (HALTED)
//     bus          instr_fetch_unit_if.master (memory port + handshake)
//     halted       HALT accepted, fetch stopped
//   Optional (IFU_PERF_CNT_EN defined):
//     fetch_count  [31:0] accepted handshakes, HALT included
//     stall_count  [15:0] HOLD cycles with ir_ready low, saturating
//
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   WAIT    | instr_addr stable, counting memory latency
//   HOLD    | ir_out valid, waiting for ir_ready
//   HALTED  | HALT accepted, outputs frozen until start
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int               ADDR_W      = 16,
  parameter int               INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int               MEM_LATENCY = 1,
  parameter int               OPC_W       = 8,
  parameter logic [OPC_W-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  instr_fetch_unit_if.master bus,
  output logic halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_HALTED} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OPC_W-1:0]   opcode;

  assign opcode = ir_q[INSTR_W-1 -: OPC_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        // start outranks a same-cycle pc_load here
        if (start) begin
          pc_d    = RESET_PC;
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.pc_load) begin
          // new address: restart the latency count, in-flight word is dropped
          pc_d  = bus.pc_load_val;
          cnt_d = LAT_LOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ir_d     = bus.instr_in;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        // redirect wins over both the handshake and HALT detection
        if (bus.pc_load) begin
          pc_d    = bus.pc_load_val;
          valid_d = 1'b0;
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end else if (bus.ir_ready) begin
          valid_d = 1'b0;
          if (opcode == HALT_OPCODE) begin
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            cnt_d   = LAT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          pc_d     = RESET_PC;
          halted_d = 1'b0;
          cnt_d    = LAT_LOAD;
          state_d  = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // instr_addr is the PC register itself, so it is stable through WAIT
  assign bus.instr_addr = pc_q;
  assign bus.ir_out     = ir_q;
  assign bus.ir_valid   = valid_q;
  assign bus.pc_out     = pc_out_q;
  assign halted         = halted_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_q;
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      // a handshake overridden by pc_load is not an accepted fetch
      if (state_q == S_HOLD && bus.ir_ready && !bus.pc_load)
        fetch_q <= fetch_q + 32'd1;
      if (state_q == S_HOLD && !bus.ir_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign fetch_count = fetch_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a 1-edge-latency memory model.
module tb_instr_fetch_unit;
  logic clock = 1'b0;
  logic reset;
  logic start;
  logic halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] stall_count;
`endif

  instr_fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  instr_fetch_unit dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bus    (bus),
    .halted (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clock = ~clock;

  // memory: word at the address presented one edge earlier
  logic [15:0] mem [0:65535];
  logic [15:0] addr_d;
  always @(posedge clock) addr_d <= bus.instr_addr;
  assign bus.instr_in = mem[addr_d];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_load_val = '0;
    bus.ir_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.ir_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.instr_addr !== 16'h0) begin n_err++; $display("FAIL reset_addr got %h want 0000", bus.instr_addr); end
    n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.ir_valid); end
    n_cmp++; if (bus.ir_out !== 16'h0) begin n_err++; $display("FAIL reset_ir got %h want 0000", bus.ir_out); end
    n_cmp++; if (bus.pc_out !== 16'h0) begin n_err++; $display("FAIL reset_pc_out got %h want 0000", bus.pc_out); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
`ifdef IFU_PERF_CNT_EN
    n_cmp++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL reset_fetch got %0d want 0", fetch_count); end
    n_cmp++; if (stall_count !== 16'd0) begin n_err++; $display("FAIL reset_stall got %0d want 0", stall_count); end
`endif
    bus.ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b want 0", bus.ir_valid); end
  endtask

  task automatic test_sequential();
    bit ok;
    int t_start, t_last;
    logic [15:0] exp_pc;
    do_reset();
    bus.ir_ready = 1'b1;
    start = 1'b1;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'h1234;
    t_start = cyc;
    step();
    start = 1'b0;
    bus.pc_load = 1'b0;
    exp_pc = 16'h0;
    t_last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_valid(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL seq_timeout word %0d got no valid want valid", k); break; end
      n_cmp++; if (bus.pc_out !== exp_pc) begin n_err++; $display("FAIL seq_pc_out got %h want %h", bus.pc_out, exp_pc); end
      n_cmp++; if (bus.ir_out !== mem[exp_pc]) begin n_err++; $display("FAIL seq_ir got %h want %h", bus.ir_out, mem[exp_pc]); end
      n_cmp++; if (bus.instr_addr !== exp_pc) begin n_err++; $display("FAIL seq_addr got %h want %h", bus.instr_addr, exp_pc); end
      if (k == 0) begin
        n_cmp++; if (cyc - t_start !== 3) begin n_err++; $display("FAIL seq_first_latency got %0d want 3", cyc - t_start); end
      end else begin
        n_cmp++; if (cyc - t_last !== 3) begin n_err++; $display("FAIL seq_interval got %0d want 3", cyc - t_last); end
      end
      t_last = cyc;
      exp_pc = exp_pc + 16'd1;
      step();
    end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(10, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stall_timeout got no valid want valid"); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (bus.ir_valid !== 1'b1 || bus.pc_out !== 16'h0 || bus.instr_addr !== 16'h0 || bus.ir_out !== mem[0])
        begin n_err++; $display("FAIL stall_hold cyc %0d got v=%b pc=%h a=%h ir=%h want v=1 pc=0000 a=0000 ir=%h", i, bus.ir_valid, bus.pc_out, bus.instr_addr, bus.ir_out, mem[0]); end
      step();
    end
`ifdef IFU_PERF_CNT_EN
    n_cmp++; if (stall_count !== 16'd10) begin n_err++; $display("FAIL stall_count got %0d want 10", stall_count); end
`endif
    bus.ir_ready = 1'b1;
    step();
    n_cmp++; if (bus.ir_valid !== 1'b0 || bus.instr_addr !== 16'h1) begin n_err++; $display("FAIL stall_release got v=%b a=%h want v=0 a=0001", bus.ir_valid, bus.instr_addr); end
`ifdef IFU_PERF_CNT_EN
    n_cmp++; if (fetch_count !== 32'd1) begin n_err++; $display("FAIL stall_fetch got %0d want 1", fetch_count); end
`endif
  endtask

  task automatic test_redirect_wait();
    bit ok;
    logic [15:0] exp_pc;
    do_reset();
    bus.ir_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'd80;
    step();
    bus.pc_load = 1'b0;
    exp_pc = 16'd80;
    for (int k = 0; k < 4; k++) begin
      wait_valid(10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL redir_timeout got no valid want valid"); break; end
      n_cmp++; if (bus.pc_out !== exp_pc) begin n_err++; $display("FAIL redir_pc_out got %h want %h", bus.pc_out, exp_pc); end
      n_cmp++; if (bus.ir_out !== mem[exp_pc]) begin n_err++; $display("FAIL redir_ir got %h want %h", bus.ir_out, mem[exp_pc]); end
      exp_pc = exp_pc + 16'd1;
      step();
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'd5;
    step();
    bus.pc_load = 1'b0;
    wait_valid(10, ok);
    n_cmp++; if (!ok || bus.pc_out !== 16'd5 || bus.ir_out !== 16'hFF00) begin n_err++; $display("FAIL hold_halt_word got ok=%b pc=%h ir=%h want pc=0005 ir=ff00", ok, bus.pc_out, bus.ir_out); end
    // redirect plus handshake on a HALT word: redirect must win
    bus.ir_ready = 1'b1;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'd40;
    step();
    bus.pc_load = 1'b0;
    n_cmp++; if (halted !== 1'b0 || bus.ir_valid !== 1'b0 || bus.instr_addr !== 16'd40) begin n_err++; $display("FAIL hold_redir got h=%b v=%b a=%h want h=0 v=0 a=0028", halted, bus.ir_valid, bus.instr_addr); end
    wait_valid(10, ok);
    n_cmp++; if (!ok || bus.pc_out !== 16'd40 || bus.ir_out !== mem[40]) begin n_err++; $display("FAIL hold_redir_word got ok=%b pc=%h ir=%h want pc=0028 ir=%h", ok, bus.pc_out, bus.ir_out, mem[40]); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    bus.ir_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'hFFFF;
    step();
    bus.pc_load = 1'b0;
    wait_valid(10, ok);
    n_cmp++; if (!ok || bus.pc_out !== 16'hFFFF || bus.ir_out !== mem[16'hFFFF]) begin n_err++; $display("FAIL wrap_top got ok=%b pc=%h ir=%h want pc=ffff ir=%h", ok, bus.pc_out, bus.ir_out, mem[16'hFFFF]); end
    step();
    n_cmp++; if (bus.instr_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr got %h want 0000", bus.instr_addr); end
    wait_valid(10, ok);
    n_cmp++; if (!ok || bus.pc_out !== 16'h0000 || bus.ir_out !== mem[0]) begin n_err++; $display("FAIL wrap_next got ok=%b pc=%h ir=%h want pc=0000 ir=%h", ok, bus.pc_out, bus.ir_out, mem[0]); end
  endtask

  task automatic test_halt();
    bit ok;
    do_reset();
    bus.ir_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_valid(10, ok);
      n_cmp++; if (!ok || bus.pc_out !== 16'(k)) begin n_err++; $display("FAIL halt_run got ok=%b pc=%h want pc=%h", ok, bus.pc_out, 16'(k)); end
      step();
    end
    n_cmp++; if (halted !== 1'b1 || bus.ir_valid !== 1'b0 || bus.instr_addr !== 16'd5) begin n_err++; $display("FAIL halt_enter got h=%b v=%b a=%h want h=1 v=0 a=0005", halted, bus.ir_valid, bus.instr_addr); end
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'd99;
    step();
    bus.pc_load = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (halted !== 1'b1 || bus.ir_valid !== 1'b0 || bus.instr_addr !== 16'd5 || bus.pc_out !== 16'd5 || bus.ir_out !== 16'hFF00)
      begin n_err++; $display("FAIL halt_frozen got h=%b v=%b a=%h pc=%h ir=%h want h=1 v=0 a=0005 pc=0005 ir=ff00", halted, bus.ir_valid, bus.instr_addr, bus.pc_out, bus.ir_out); end
`ifdef IFU_PERF_CNT_EN
    n_cmp++; if (fetch_count !== 32'd6) begin n_err++; $display("FAIL halt_fetch got %0d want 6", fetch_count); end
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (halted !== 1'b0 || bus.instr_addr !== 16'h0) begin n_err++; $display("FAIL halt_restart got h=%b a=%h want h=0 a=0000", halted, bus.instr_addr); end
    wait_valid(10, ok);
    n_cmp++; if (!ok || bus.pc_out !== 16'h0 || bus.ir_out !== mem[0]) begin n_err++; $display("FAIL halt_resume got ok=%b pc=%h ir=%h want pc=0000 ir=%h", ok, bus.pc_out, bus.ir_out, mem[0]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'd30;
    step();
    bus.pc_load = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (bus.instr_addr !== 16'h0 || bus.ir_valid !== 1'b0 || bus.ir_out !== 16'h0 || bus.pc_out !== 16'h0 || halted !== 1'b0)
      begin n_err++; $display("FAIL rst_wait got a=%h v=%b ir=%h pc=%h h=%b want all 0", bus.instr_addr, bus.ir_valid, bus.ir_out, bus.pc_out, halted); end
    for (int i = 0; i < 6; i++) step();
    n_cmp++; if (bus.ir_valid !== 1'b0 || bus.instr_addr !== 16'h0) begin n_err++; $display("FAIL rst_wait_idle got v=%b a=%h want v=0 a=0000", bus.ir_valid, bus.instr_addr); end
    start = 1'b1;
    step();
    start = 1'b0;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'd30;
    step();
    bus.pc_load = 1'b0;
    wait_valid(10, ok);
    n_cmp++; if (!ok || bus.pc_out !== 16'd30) begin n_err++; $display("FAIL rst_hold_setup got ok=%b pc=%h want pc=001e", ok, bus.pc_out); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (bus.instr_addr !== 16'h0 || bus.ir_valid !== 1'b0 || bus.ir_out !== 16'h0 || bus.pc_out !== 16'h0 || halted !== 1'b0)
      begin n_err++; $display("FAIL rst_hold got a=%h v=%b ir=%h pc=%h h=%b want all 0", bus.instr_addr, bus.ir_valid, bus.ir_out, bus.pc_out, halted); end
`ifdef IFU_PERF_CNT_EN
    n_cmp++; if (stall_count !== 16'd0 || fetch_count !== 32'd0) begin n_err++; $display("FAIL rst_hold_cnt got s=%0d f=%0d want 0 0", stall_count, fetch_count); end
`endif
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (bus.ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_idle got v=%b want 0", bus.ir_valid); end
  endtask

  // Transaction-level model: the PC the next presented word must carry,
  // advanced on accepted handshakes and replaced on redirects.
  task automatic test_random();
    logic [15:0] exp_pc;
    int exp_fetch, exp_stall, idle;
    bit rdy, ld;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    bus.pc_load = 1'b1;
    bus.pc_load_val = 16'd1000;
    step();
    bus.pc_load = 1'b0;
    exp_pc = 16'd1000;
    exp_fetch = 0;
    exp_stall = 0;
    idle = 0;
    for (int c = 0; c < 2000; c++) begin
      if (bus.ir_valid === 1'b1) begin
        idle = 0;
        n_cmp++; if (bus.pc_out !== exp_pc || bus.ir_out !== mem[exp_pc] || bus.instr_addr !== exp_pc)
          begin n_err++; $display("FAIL rand_word cyc %0d got pc=%h ir=%h a=%h want pc=%h ir=%h", c, bus.pc_out, bus.ir_out, bus.instr_addr, exp_pc, mem[exp_pc]); end
      end else begin
        idle++;
      end
      if (idle > 30) begin
        n_cmp++; n_err++;
        $display("FAIL rand_progress got %0d idle cycles want <=30", idle);
        break;
      end
      rdy = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 15) == 0);
      bus.ir_ready = rdy;
      bus.pc_load = ld;
      if (bus.ir_valid === 1'b1 && !rdy) exp_stall++;
      if (ld) begin
        bus.pc_load_val = 16'($urandom_range(100, 60000));
        exp_pc = bus.pc_load_val;
      end else if (bus.ir_valid === 1'b1 && rdy) begin
        exp_pc = exp_pc + 16'd1;
        exp_fetch++;
      end
      step();
    end
    bus.pc_load = 1'b0;
`ifdef IFU_PERF_CNT_EN
    n_cmp++; if (fetch_count !== 32'(exp_fetch)) begin n_err++; $display("FAIL rand_fetch got %0d want %0d", fetch_count, exp_fetch); end
    n_cmp++; if (stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL rand_stall got %0d want %0d", stall_count, exp_stall); end
`endif
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if (w[15:8] == 8'hFF) w[15:8] = 8'h7F;
      mem[i] = w;
    end
    mem[5] = 16'hFF00;
    reset = 1'b1;
    start = 1'b0;
    bus.ir_ready = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_load_val = '0;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no finish want finish before 1ms");
    $fatal(1);
  end

endmodule
